// File: rtl/twiddle_bank_storage.sv
// Twiddle-factor store with forward and inverse banks, one table per PE channel per bank.
// Tables are loaded through a streaming beat port and read back through a 2-cycle pipeline.
module twiddle_bank_storage #(
  parameter int DLEN   = 32,
  parameter int HLEN   = 9,
  parameter int PE_NUM = 4,
  parameter int DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_mode,
  input  logic                     load_valid,
  input  logic [DLEN-1:0]          load_data,
  output logic                     load_ready,
  output logic                     load_done,
  output logic [1:0]               table_ok,
  input  logic                     rd_en,
  input  logic                     mode,
  input  logic [HLEN-1:0]          raddr,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic [PE_NUM*DLEN-1:0]   dout
);

  localparam int TOTAL = PE_NUM * DEPTH;
  localparam int KW    = $clog2(TOTAL);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} loadState_e;

  loadState_e        state_q, state_d;
  logic              lbank_q, lbank_d;
  logic [KW-1:0]     k_q, k_d;
  logic [1:0]        tableOk_q, tableOk_d;
  logic              beatAccept;
  logic              lastBeat;
  logic [KW-1:0]     wChan;
  logic [KW-1:0]     wRow;
  logic [AW-1:0]     wAddr;
  logic [AW-1:0]     rIdx;
  logic              reqErr;
  logic              s1Valid_q, s1Err_q, s1Mode_q;
  logic              rdValid_q, rdErr_q;
  logic [PE_NUM*DLEN-1:0] dout_q, dout_d;
  logic [PE_NUM*DLEN-1:0] rdW, rdI;

  assign beatAccept = (state_q == LOAD) && load_valid;
  assign lastBeat   = (k_q == KW'(TOTAL - 1));

  // Beats are interleaved across channels: channel = k mod PE_NUM, row = k / PE_NUM.
  assign wChan = k_q % KW'(PE_NUM);
  assign wRow  = k_q / KW'(PE_NUM);
  assign wAddr = wRow[AW-1:0];
  assign rIdx  = raddr[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lbank_q   <= 1'b0;
      k_q       <= '0;
      tableOk_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      lbank_q   <= lbank_d;
      k_q       <= k_d;
      tableOk_q <= tableOk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lbank_d   = lbank_q;
    k_d       = k_q;
    tableOk_d = tableOk_q;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          lbank_d              = load_mode;
          tableOk_d[load_mode] = 1'b0;
          k_d                  = '0;
          state_d              = LOAD;
        end
      end
      LOAD: begin
        if (beatAccept) begin
          k_d = k_q + 1'b1;
          if (lastBeat) state_d = DONE;
        end
      end
      DONE: begin
        tableOk_d[lbank_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      LOAD:    load_ready = 1'b1;
      DONE:    load_done  = 1'b1;
      default: ;
    endcase
  end

  assign table_ok = tableOk_q;

  // Reads into the bank under load are flagged, so a same-address write/read race never matters.
  assign reqErr = !tableOk_q[mode]
                || ((state_q != IDLE) && (lbank_q == mode))
                || (int'(raddr) >= DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      s1Err_q   <= 1'b0;
      s1Mode_q  <= 1'b0;
    end else begin
      s1Valid_q <= rd_en;
      s1Err_q   <= reqErr;
      s1Mode_q  <= mode;
    end
  end

  for (genvar c = 0; c < PE_NUM; c++) begin : gChan
    (* ram_style = "block" *) logic [DLEN-1:0] ramW [DEPTH];
    (* ram_style = "block" *) logic [DLEN-1:0] ramI [DEPTH];
    logic [DLEN-1:0] rdataW_q, rdataI_q;
    logic            wrHere;

    assign wrHere = beatAccept && (wChan == KW'(c));

    always_ff @(posedge clk) begin
      if (wrHere && !lbank_q) ramW[wAddr] <= load_data;
      if (rd_en) rdataW_q <= ramW[rIdx];
    end

    always_ff @(posedge clk) begin
      if (wrHere && lbank_q) ramI[wAddr] <= load_data;
      if (rd_en) rdataI_q <= ramI[rIdx];
    end

    assign rdW[c*DLEN +: DLEN] = rdataW_q;
    assign rdI[c*DLEN +: DLEN] = rdataI_q;
  end

  always_comb begin
    dout_d = dout_q;
    if (s1Valid_q) dout_d = s1Err_q ? '0 : (s1Mode_q ? rdI : rdW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdValid_q <= 1'b0;
      rdErr_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      rdValid_q <= s1Valid_q;
      rdErr_q   <= s1Valid_q && s1Err_q;
      dout_q    <= dout_d;
    end
  end

  assign rd_valid = rdValid_q;
  assign rd_err   = rdErr_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_twiddle_bank_storage.sv
// Self-checking bench for twiddle_bank_storage: directed loads and reads, a vector table,
// and randomized traffic compared every cycle against a behavioural model of the store.
module tb_twiddle_bank_storage;

  localparam int DLEN   = 32;
  localparam int HLEN   = 10;
  localparam int PE_NUM = 4;
  localparam int DEPTH  = 512;
  localparam int TOTAL  = PE_NUM * DEPTH;
  localparam int DW     = PE_NUM * DLEN;
  localparam int AWT    = $clog2(DEPTH);

  logic            clk, reset;
  logic            load_start, load_mode, load_valid;
  logic [DLEN-1:0] load_data;
  logic            load_ready, load_done;
  logic [1:0]      table_ok;
  logic            rd_en, mode;
  logic [HLEN-1:0] raddr;
  logic            rd_valid, rd_err;
  logic [DW-1:0]   dout;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic            m;
    logic [HLEN-1:0] a;
    logic            e;
    logic [DW-1:0]   d;
  } vec_t;

  vec_t vecs [7];

  twiddle_bank_storage #(
    .DLEN(DLEN), .HLEN(HLEN), .PE_NUM(PE_NUM), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_mode(load_mode), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .table_ok(table_ok), .rd_en(rd_en), .mode(mode), .raddr(raddr),
    .rd_valid(rd_valid), .rd_err(rd_err), .dout(dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      if (nFail <= 40) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: memory as arrays indexed by beat arithmetic, load progress as a phase.
  logic [DLEN-1:0] refMem [2][PE_NUM][DEPTH];
  logic [1:0]      mOk;
  int              mPhase;
  logic            mBank;
  int              mCount;
  bit              started = 0;
  logic            curV, curE, pendV, pendE;
  logic [DW-1:0]   curD, pendD, mDout;

  always @(posedge clk) begin
    if (reset) begin
      mPhase = 0; mOk = 2'b00; mCount = 0; mBank = 1'b0;
      curV = 0; curE = 0; curD = '0;
      pendV = 0; pendE = 0; pendD = '0; mDout = '0;
      started = 1;
    end else begin
      curV = rd_en; curE = 0; curD = '0;
      if (rd_en) begin
        curE = !mOk[mode] || (mPhase != 0 && mBank == mode) || (int'(raddr) >= DEPTH);
        if (!curE)
          for (int c = 0; c < PE_NUM; c++) curD[c*DLEN +: DLEN] = refMem[mode][c][raddr[AWT-1:0]];
      end
      if (mPhase == 2) begin
        mOk[mBank] = 1'b1;
        mPhase = 0;
      end else if (mPhase == 1) begin
        if (load_valid) begin
          refMem[mBank][mCount % PE_NUM][mCount / PE_NUM] = load_data;
          mCount++;
          if (mCount == TOTAL) mPhase = 2;
        end
      end else if (load_start) begin
        mBank = load_mode; mOk[load_mode] = 1'b0; mCount = 0; mPhase = 1;
      end
    end
    #1;
    if (started) begin
      if (pendV) mDout = pendE ? '0 : pendD;
      checkOutput("mon rd_valid", DW'(rd_valid), DW'(pendV));
      checkOutput("mon rd_err", DW'(rd_err), DW'(pendV && pendE));
      checkOutput("mon dout", dout, mDout);
      checkOutput("mon load_ready", DW'(load_ready), DW'(mPhase == 1));
      checkOutput("mon load_done", DW'(load_done), DW'(mPhase == 2));
      checkOutput("mon table_ok", DW'(table_ok), DW'(mOk));
    end
    pendV = curV; pendE = curE; pendD = curD;
  end

  task automatic readCheck(input string name, input logic m, input logic [HLEN-1:0] a,
                           input logic e, input logic [DW-1:0] d);
    @(negedge clk);
    rd_en = 1'b1; mode = m; raddr = a;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    checkOutput({name, " valid"}, DW'(rd_valid), DW'(1'b1));
    checkOutput({name, " err"}, DW'(rd_err), DW'(e));
    checkOutput({name, " dout"}, dout, d);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    readCheck($sformatf("vec%0d", idx), v.m, v.a, v.e, v.d);
  endtask

  task automatic loadBank(input logic bank, input logic [DLEN-1:0] base, input bit gappy, input int abortAt);
    int   k = 0;
    int   cyc = 0;
    logic v, rdy;
    @(negedge clk);
    load_start = 1'b1; load_mode = bank;
    @(negedge clk);
    load_start = 1'b0;
    while (k < TOTAL && cyc < 4 * TOTAL) begin
      if (k == abortAt) begin
        load_valid = 1'b1; load_data = base + DLEN'(k); reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; load_valid = 1'b0;
        checkOutput("abort load_ready", DW'(load_ready), DW'(1'b0));
        checkOutput("abort table_ok", DW'(table_ok), DW'(2'b00));
        repeat (4) begin
          @(negedge clk);
          checkOutput("abort no load_done", DW'(load_done), DW'(1'b0));
        end
        return;
      end
      rdy = load_ready;
      v = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      load_valid = v; load_data = base + DLEN'(k);
      @(negedge clk);
      if (v && rdy) k++;
      cyc++;
    end
    load_valid = 1'b0;
    checkOutput("load beats accepted", DW'(k), DW'(TOTAL));
    checkOutput("load_done pulse", DW'(load_done), DW'(1'b1));
    @(negedge clk);
    checkOutput("load_done one cycle", DW'(load_done), DW'(1'b0));
    checkOutput("table_ok bit set", DW'(table_ok[bank]), DW'(1'b1));
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_mode = 1'b0; load_valid = 1'b0;
    load_data = '0; rd_en = 1'b0; mode = 1'b0; raddr = '0;

    vecs[0] = '{1'b0, 10'd5,    1'b0, {32'd23, 32'd22, 32'd21, 32'd20}};
    vecs[1] = '{1'b1, 10'd511,  1'b0, {32'h17FF, 32'h17FE, 32'h17FD, 32'h17FC}};
    vecs[2] = '{1'b0, 10'd0,    1'b0, {32'd3, 32'd2, 32'd1, 32'd0}};
    vecs[3] = '{1'b0, 10'd511,  1'b0, {32'd2047, 32'd2046, 32'd2045, 32'd2044}};
    vecs[4] = '{1'b0, 10'd512,  1'b1, '0};
    vecs[5] = '{1'b1, 10'd1023, 1'b1, '0};
    vecs[6] = '{1'b1, 10'd0,    1'b0, {32'h1003, 32'h1002, 32'h1001, 32'h1000}};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset load_ready", DW'(load_ready), DW'(1'b0));
    checkOutput("reset load_done", DW'(load_done), DW'(1'b0));
    checkOutput("reset table_ok", DW'(table_ok), DW'(2'b00));
    checkOutput("reset rd_valid", DW'(rd_valid), DW'(1'b0));
    checkOutput("reset dout", dout, '0);
    readCheck("unloaded read", 1'b0, '0, 1'b1, '0);

    loadBank(1'b0, 32'h0, 1'b0, -1);
    checkOutput("fwd table_ok", DW'(table_ok), DW'(2'b01));
    readCheck("fwd raddr5", 1'b0, 10'd5, 1'b0, {32'd23, 32'd22, 32'd21, 32'd20});

    loadBank(1'b1, 32'h1000, 1'b1, -1);
    checkOutput("both table_ok", DW'(table_ok), DW'(2'b11));
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Forward reads stream back-to-back while the inverse bank reloads.
    fork
      loadBank(1'b1, 32'h2000, 1'b0, -1);
      begin : readers
        int cnt = 0;
        for (int j = 0; j < 517; j++) begin
          @(negedge clk);
          if (rd_valid) cnt++;
          if (j == 514) begin
            checkOutput("busy bank read err", DW'(rd_err), DW'(1'b1));
            checkOutput("busy bank read dout", dout, '0);
          end
          rd_en = (j < 513); mode = (j == 512); raddr = HLEN'((j < 512) ? j : 3);
        end
        rd_en = 1'b0;
        checkOutput("valid run length", DW'(cnt), DW'(513));
      end
    join

    @(negedge clk);
    rd_en = 1'b1; mode = 1'b0; raddr = 10'd512;
    @(negedge clk);
    raddr = 10'd511;
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("oob valid", DW'(rd_valid), DW'(1'b1));
    checkOutput("oob err", DW'(rd_err), DW'(1'b1));
    checkOutput("oob dout", dout, '0);
    @(negedge clk);
    checkOutput("after oob err", DW'(rd_err), DW'(1'b0));
    checkOutput("after oob dout", dout, {32'd2047, 32'd2046, 32'd2045, 32'd2044});

    loadBank(1'b1, 32'h5000, 1'b0, 1000);
    loadBank(1'b1, 32'h3000, 1'b1, -1);
    checkOutput("reload table_ok", DW'(table_ok), DW'(2'b10));
    readCheck("inv reload raddr7", 1'b1, 10'd7, 1'b0, {32'h301F, 32'h301E, 32'h301D, 32'h301C});

    fork
      loadBank(1'b0, 32'h4000, 1'b1, -1);
      begin : randReads
        repeat (3000) begin
          @(negedge clk);
          rd_en = 1'($urandom_range(0, 1));
          mode  = 1'($urandom_range(0, 1));
          raddr = HLEN'($urandom_range(0, 600));
        end
        rd_en = 1'b0;
      end
    join
    readCheck("fwd rand reload", 1'b0, 10'd100, 1'b0, {32'h4193, 32'h4192, 32'h4191, 32'h4190});

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #5000000;
    nFail++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/twiddle_bank_storage.md
Name: twiddle_bank_storage

Overview:
- Runtime-loadable twiddle-factor store feeding all NTT/INTT processing elements in parallel.
- Holds two banks, forward (W) and inverse (WINV), each with one DEPTH-entry table per PE channel.
- Tables are loaded over a streaming write port instead of fixed init files.
- Reads return one word per PE per access, with a registered 2-cycle pipeline and an error flag.

Parameters:
DLEN, 32, coefficient/twiddle word width in bits
HLEN, 9, read address width
PE_NUM, 4, number of PE channels read in parallel (power of two, 1..32)
DEPTH, 512, entries per channel per bank (DEPTH <= 2^HLEN)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
load_start  in  1  pulse; begins loading the bank given by load_mode
load_mode  in  1  0 = forward bank, 1 = inverse bank (sampled with load_start)
load_valid  in  1  write beat valid
load_data  in  DLEN  write beat data
load_ready  out  1  high while the block accepts write beats
load_done  out  1  one-cycle pulse after the last beat is written
table_ok  out  2  bit0 = forward bank loaded, bit1 = inverse bank loaded
rd_en  in  1  read request
mode  in  1  read bank select: 0 = forward, 1 = inverse
raddr  in  HLEN  read address, common to all channels
rd_valid  out  1  read data valid
rd_err  out  1  read error, aligned with rd_valid
dout  out  PE_NUM*DLEN  channel c data in bits [c*DLEN +: DLEN]

Behaviour:
- Reset values: load_ready=0, load_done=0, table_ok=00, rd_valid=0, rd_err=0, dout=0. FSM goes to IDLE and all counters clear. Memory contents are not cleared.
- Load FSM states:
  - IDLE: on load_start, latch load_mode into lbank, clear table_ok[lbank], clear beat counter k, go to LOAD.
  - LOAD: load_ready=1. A beat is accepted when load_valid && load_ready. Beat k writes channel (k mod PE_NUM), address (k / PE_NUM), bank lbank. After beat PE_NUM*DEPTH-1 is accepted, go to DONE; load_ready drops on the next cycle.
  - DONE: load_done=1 for exactly one cycle, set table_ok[lbank]=1, return to IDLE.
- load_start outside IDLE is ignored. load_valid outside LOAD is ignored.
- Read pipeline, fixed latency 2:
  - Cycle 0: rd_en/mode/raddr sampled.
  - Cycle 1: RAM registered read.
  - Cycle 2: output register; rd_valid=1.
- Reads are fully pipelined: one request per cycle, with no bubbles for back-to-back rd_en.
- rd_err=1 (and dout forced to 0 in that beat) when any of these hold:
  - table_ok[mode]==0 at request time;
  - FSM in LOAD or DONE with lbank==mode;
  - raddr >= DEPTH.
- When rd_valid=0, dout holds its previous value and rd_err=0.
- Reading the bank not being loaded is permitted during a load and returns valid data.
- A write and a read to the same bank, channel and address in the same cycle cannot occur, because such reads are flagged as errors.
- Reset mid-load aborts the load. table_ok is cleared for both banks, and any in-flight read beats are dropped (rd_valid=0 the cycle after reset).
- Memory is inferred as PE_NUM x 2 independent simple-dual-port RAMs (ram_style "block").

Test Plan:
1. Assert reset for 2 cycles, then release -> all outputs 0, table_ok=00, load_ready=0; rd_en with raddr=0 -> rd_valid=1, rd_err=1, dout=0 two cycles later.
2. PE_NUM=4, DEPTH=512: load forward bank, streaming load_data=k for k=0..2047 -> load_done pulses one cycle after beat 2047, table_ok=01. Then read mode=0, raddr=5 -> 2 cycles later dout={23,22,21,20} (channel 3 in the upper bits), rd_err=0.
3. Load inverse bank with load_valid toggling randomly (about 50% duty) and load_data=0x1000+k -> same contents as a gap-free load. Then read mode=1, raddr=511 -> dout={0x17FF,0x17FE,0x17FD,0x17FC}.
4. During an inverse-bank load, issue back-to-back forward reads with raddr=0..511 -> rd_valid high for 512 consecutive cycles with correct data. A read with mode=1 in the same window -> rd_err=1, dout=0.
5. raddr=512 with DEPTH=512 and the bank loaded -> rd_err=1, dout=0. raddr=511 on the next cycle -> correct data, rd_err=0.
6. Assert reset at beat 1000 of an inverse-bank load -> load_ready=0 on the next cycle, table_ok=00, no load_done pulse. A subsequent load_start is accepted and completes normally.
